ant_neighbour_scan: RTL and testbench
=====================================

Name: ant_neighbour_scan

Overview:
- Sequential initiator for the view-location query interface.
- Given an ant position and heading, it walks `viewLoc_x`/`viewLoc_y` over the 8 neighbouring cells and samples the 1-bit `sense` response returned by the world map.
- It assembles an 8-bit neighbour mask in absolute compass order, plus a heading-relative copy.
- It sits between the ant controller (which issues `start`) and the map/occupancy responders (which answer `sense` one cycle after each probe).

Parameters:
- `X_bits`, 10, width of x coordinate.
- `Y_bits`, 9, width of y coordinate.
- `X_MAX`, 640, grid width in cells; legal x is 0..X_MAX-1.
- `Y_MAX`, 480, grid height in cells; legal y is 0..Y_MAX-1.

Ports:
- `Clk`  in  1  system clock.
- `Reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `x`  in  X_bits  ant x; captured on accepted start.
- `y`  in  Y_bits  ant y; captured on accepted start.
- `dir`  in  3  heading: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW; captured on accepted start.
- `viewLoc_x`  out  X_bits  probe x, registered.
- `viewLoc_y`  out  Y_bits  probe y, registered.
- `viewValid`  out  1  probe on `viewLoc` is valid this cycle.
- `sense`  in  1  responder answer, valid exactly 1 cycle after the matching `viewValid`.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse; masks valid.
- `mask`  out  8  bit k = sense of neighbour in direction k (absolute).
- `rel_mask`  out  8  `rel_mask[i] = mask[(dir_q+i) mod 8]`; bit0 = cell ahead.
- `any_hit`  out  1  OR of `mask`.

Behaviour:
- Reset (`Reset_n`=0 at a Clk edge): state IDLE; all outputs 0; captured x/y/dir cleared.
  - Reset mid-scan aborts immediately; any in-flight `sense` is discarded.
- Neighbour offsets (dx, dy), y increases downward:
  - k=0 (0,-1); 1 (+1,-1); 2 (+1,0); 3 (+1,+1)
  - k=4 (0,+1); 5 (-1,+1); 6 (-1,0); 7 (-1,-1)
- Arithmetic: offsets are applied in X_bits+1 / Y_bits+1 signed width. A result is out-of-bounds if it is <0, >=X_MAX (x), or >=Y_MAX (y).
- FSM states:
  - IDLE: if `start`, capture x/y/dir, clear `mask`, k=0, set `busy`, go to SCAN.
  - SCAN: each cycle drive probe k on `viewLoc` (registered) with `viewValid`=1 for in-bounds cells; k++. Leave after k=7 to DRAIN.
  - DRAIN: one cycle; captures the last response.
  - DONE: `done`=1 for one cycle, `busy`=0 on exit; return to IDLE.
- Sampling: on every cycle after a probe cycle, `mask[k_prev]` <= `sense & viewValid_prev`. Out-of-bounds probes therefore yield 0.
- Latency:
  - Accepted start at edge T0.
  - Probes k=0..7 are on cycles T1..T8.
  - DRAIN at T9.
  - `done` high during T10.
  - Next start is accepted at T11 at the earliest. Throughput is 1 scan per 11 cycles.
- Output hold: `mask`, `rel_mask` and `any_hit` are held from `done` until the next accepted start, which clears them. During a scan they show partial values and must not be used.
- `start` while `busy` is ignored; the request is not queued.
- Input changes to `x`/`y`/`dir` during a scan have no effect.
- `viewLoc` holds its last value when `viewValid`=0.

Optional Feature:
- Macro: `ANT_SCAN_EDGE_WRAP_EN`.
- Defined: the grid is a torus. Out-of-range coordinates wrap: x=-1 becomes X_MAX-1, x=X_MAX becomes 0, and likewise for y. All 8 probes are issued with `viewValid`=1.
- Undefined: out-of-bounds neighbours get `viewValid`=0, and their mask bit is forced to 0. Timing is identical in both builds (always 8 probe slots).

Decomposition:
- `ant_pkg`:
  - `dir_t` enum (N..NW).
  - Constant `DX[8]`, `DY[8]` offset tables.
  - `X_bits`, `Y_bits`, `X_MAX`, `Y_MAX` defaults.
  - `scan_state_t` enum {IDLE, SCAN, DRAIN, DONE}.
  - Function `rot8(mask, dir)`.
- Sub-module `ant_neighbour_addr`: combinational.
  - Inputs: (x, y, k).
  - Outputs: (nx, ny, in_bounds).
  - Contains the offset and the wrap/clamp logic selected by the macro.
  - Reused by the ant movement controller.

Test Plan:
1. Reset: hold `Reset_n`=0 for 2 cycles mid-scan (start at cycle 0, reset at cycle 4) -> `busy`=0, `done`=0, `mask`=0, `viewValid`=0 on the next cycle; no `done` pulse follows.
2. Interior scan: x=100, y=100, dir=0; responder returns 1 only at (101,99) -> probe sequence (100,99), (101,99), (101,100) … (99,99) on T1..T8; `done` at T10; `mask`=8'b0000_0010, `rel_mask`=8'b0000_0010, `any_hit`=1.
3. Heading rotation: same stimulus as test 2 with dir=2 -> `mask`=8'b0000_0010, `rel_mask`=8'b1000_0000.
4. Corner, no wrap (macro undefined): x=0, y=0; responder always 1 -> `viewValid` low for k=0, 1, 5, 6, 7; `mask`=8'b0001_1100.
5. Corner, wrap (macro defined): x=0, y=0; responder always 1 -> k=7 probe at (X_MAX-1, Y_MAX-1); all `viewValid`=1; `mask`=8'hFF.
6. Back-to-back starts: `start` held high continuously -> `done` every 11 cycles; a `start` during `busy` is ignored; `x` changed at T3 does not alter the probes of the current scan.

Source files
------------

// File: rtl/ant_pkg.sv
// Shared types, neighbour offset tables and helpers for the ant neighbour scanner.
// Build option ANT_SCAN_EDGE_WRAP_EN (used by ant_neighbour_addr) turns the grid into a torus.
package ant_pkg;

    localparam int X_BITS_DEF = 10;
    localparam int Y_BITS_DEF = 9;
    localparam int X_MAX_DEF  = 640;
    localparam int Y_MAX_DEF  = 480;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Compass offsets, index = direction; y grows downward.
    localparam logic signed [1:0] DX [8] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1, -2'sd1, -2'sd1};
    localparam logic signed [1:0] DY [8] = '{-2'sd1, -2'sd1, 2'sd0, 2'sd1, 2'sd1, 2'sd1, 2'sd0, -2'sd1};

    // Heading-relative view: result bit i is mask bit (d+i) mod 8.
    function automatic logic [7:0] rot8(input logic [7:0] m, input logic [2:0] d);
        logic [7:0] r;
        logic [2:0] idx;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            idx  = d + 3'(i);
            r[i] = m[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/ant_neighbour_addr.sv
// Combinational neighbour address: applies the direction-k offset to (x, y) and
// either flags out-of-grid cells or wraps them (ANT_SCAN_EDGE_WRAP_EN defined).
module ant_neighbour_addr
    import ant_pkg::*;
#(
    parameter int X_bits = X_BITS_DEF,
    parameter int Y_bits = Y_BITS_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF
)(
    input  logic [X_bits-1:0] x,
    input  logic [Y_bits-1:0] y,
    input  logic [2:0]        k,
    output logic [X_bits-1:0] nx,
    output logic [Y_bits-1:0] ny,
    output logic              in_bounds
);

    logic signed [X_bits:0] sx_s;
    logic signed [Y_bits:0] sy_s;
    logic x_lo_s, x_hi_s, y_lo_s, y_hi_s;

    // Offset in one-bit-wider signed arithmetic, then classify against the grid edges.
    always_comb begin
        sx_s   = $signed({1'b0, x}) + $signed({{(X_bits-1){DX[k][1]}}, DX[k]});
        sy_s   = $signed({1'b0, y}) + $signed({{(Y_bits-1){DY[k][1]}}, DY[k]});
        x_lo_s = sx_s[X_bits];
        y_lo_s = sy_s[Y_bits];
        x_hi_s = !x_lo_s && ({1'b0, sx_s[X_bits-1:0]} >= (X_bits+1)'(X_MAX));
        y_hi_s = !y_lo_s && ({1'b0, sy_s[Y_bits-1:0]} >= (Y_bits+1)'(Y_MAX));
    end

`ifdef ANT_SCAN_EDGE_WRAP_EN
    // Torus: one step past either edge lands on the opposite edge.
    always_comb begin
        if (x_lo_s) begin
            nx = (X_bits)'(X_MAX - 1);
        end else if (x_hi_s) begin
            nx = {X_bits{1'b0}};
        end else begin
            nx = sx_s[X_bits-1:0];
        end
        if (y_lo_s) begin
            ny = (Y_bits)'(Y_MAX - 1);
        end else if (y_hi_s) begin
            ny = {Y_bits{1'b0}};
        end else begin
            ny = sy_s[Y_bits-1:0];
        end
        in_bounds = 1'b1;
    end
`else
    // Bounded grid: the address is meaningless when in_bounds is low.
    always_comb begin
        nx        = sx_s[X_bits-1:0];
        ny        = sy_s[Y_bits-1:0];
        in_bounds = !(x_lo_s || x_hi_s || y_lo_s || y_hi_s);
    end
`endif

endmodule

// File: rtl/ant_neighbour_scan.sv
// Walks the 8 neighbours of an ant over the view-location interface and collects the
// 1-cycle-delayed sense answers into an absolute and a heading-relative mask.
// Edge behaviour follows ANT_SCAN_EDGE_WRAP_EN (see ant_neighbour_addr).
module ant_neighbour_scan
    import ant_pkg::*;
#(
    parameter int X_bits = X_BITS_DEF,
    parameter int Y_bits = Y_BITS_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF
)(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [X_bits-1:0] x,
    input  logic [Y_bits-1:0] y,
    input  logic [2:0]        dir,
    output logic [X_bits-1:0] viewLoc_x,
    output logic [Y_bits-1:0] viewLoc_y,
    output logic              viewValid,
    input  logic              sense,
    output logic              busy,
    output logic              done,
    output logic [7:0]        mask,
    output logic [7:0]        rel_mask,
    output logic              any_hit
);

    scan_state_t       state_r, state_s;
    logic [2:0]        k_r, k_s;
    logic              capture_s, issue_s, done_s, busy_s;
    logic [X_bits-1:0] x_r;
    logic [Y_bits-1:0] y_r;
    dir_t              dir_r;
    logic [X_bits-1:0] nx_s;
    logic [Y_bits-1:0] ny_s;
    logic              in_bounds_s;
    logic              slot_r;
    logic [2:0]        probe_k_r;
    logic              pend_slot_r, pend_vv_r;
    logic [2:0]        pend_k_r;
    logic [7:0]        mask_s;

    ant_neighbour_addr #(
        .X_bits (X_bits),
        .Y_bits (Y_bits),
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX)
    ) u_addr (
        .x         (x_r),
        .y         (y_r),
        .k         (k_r),
        .nx        (nx_s),
        .ny        (ny_s),
        .in_bounds (in_bounds_s)
    );

    // Next-state and control decode; SCAN issues one probe per cycle for k = 0..7.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        capture_s = 1'b0;
        issue_s   = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = SCAN;
                    k_s       = 3'd0;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            SCAN: begin
                issue_s = 1'b1;
                k_s     = k_r + 3'd1;
                if (k_r == 3'd7) begin
                    state_s = DRAIN;
                end else begin
                    state_s = SCAN;
                end
            end
            DRAIN: begin
                state_s = DONE;
            end
            DONE: begin
                state_s = IDLE;
                done_s  = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Sense answers the probe shown two edges earlier; the pend_* stage carries its slot.
    always_comb begin
        mask_s = mask;
        if (capture_s) begin
            mask_s = 8'd0;
        end else if (pend_slot_r) begin
            mask_s[pend_k_r] = sense & pend_vv_r;
        end else begin
            mask_s = mask;
        end
    end

    // State, captured request, probe pipeline and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            k_r         <= 3'd0;
            x_r         <= {X_bits{1'b0}};
            y_r         <= {Y_bits{1'b0}};
            dir_r       <= DIR_N;
            viewLoc_x   <= {X_bits{1'b0}};
            viewLoc_y   <= {Y_bits{1'b0}};
            viewValid   <= 1'b0;
            slot_r      <= 1'b0;
            probe_k_r   <= 3'd0;
            pend_slot_r <= 1'b0;
            pend_vv_r   <= 1'b0;
            pend_k_r    <= 3'd0;
            mask        <= 8'd0;
            rel_mask    <= 8'd0;
            any_hit     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            if (capture_s) begin
                x_r   <= x;
                y_r   <= y;
                dir_r <= dir_t'(dir);
            end
            if (issue_s) begin
                slot_r    <= 1'b1;
                probe_k_r <= k_r;
                viewValid <= in_bounds_s;
                if (in_bounds_s) begin
                    viewLoc_x <= nx_s;
                    viewLoc_y <= ny_s;
                end
            end else begin
                slot_r    <= 1'b0;
                viewValid <= 1'b0;
            end
            pend_slot_r <= slot_r;
            pend_vv_r   <= viewValid;
            pend_k_r    <= probe_k_r;
            mask        <= mask_s;
            rel_mask    <= rot8(mask_s, dir_r);
            any_hit     <= |mask_s;
            busy        <= busy_s;
            done        <= done_s;
        end
    end

endmodule

// File: tb/tb_ant_neighbour_scan.sv
// Directed bench for ant_neighbour_scan: a bench-side responder answers probes one cycle
// late, and a scoreboard holds the expected probe stream and per-scan results.
module tb_ant_neighbour_scan;
    import ant_pkg::*;

    localparam int XB = 10;
    localparam int YB = 9;
    localparam int XM = 640;
    localparam int YM = 480;
    localparam int DXT [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    localparam int DYT [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    logic          Clk = 1'b0;
    logic          Reset_n, start, sense;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [2:0]    dir;
    logic [XB-1:0] viewLoc_x;
    logic [YB-1:0] viewLoc_y;
    logic          viewValid, busy, done, any_hit;
    logic [7:0]    mask, rel_mask;

    always #5 Clk = ~Clk;

    ant_neighbour_scan #(.X_bits(XB), .Y_bits(YB), .X_MAX(XM), .Y_MAX(YM)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .x(x), .y(y), .dir(dir),
        .viewLoc_x(viewLoc_x), .viewLoc_y(viewLoc_y), .viewValid(viewValid),
        .sense(sense), .busy(busy), .done(done), .mask(mask), .rel_mask(rel_mask),
        .any_hit(any_hit)
    );

    typedef struct packed { logic [XB-1:0] px; logic [YB-1:0] py; } probe_t;
    typedef struct packed { logic [7:0] m; logic [7:0] r; logic a; } res_t;

    probe_t probe_q[$];
    res_t   res_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     mode = 0;
    logic   resp_pend = 1'b0;
    logic   sb_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input int md, input int cx, input int cy);
        if (md == 0) return (cx == 101) && (cy == 99);
        else if (md == 1) return 1'b1;
        else return ((cx + cy) % 2) == 1;
    endfunction

    function automatic bit nb(input int cx, input int cy, input int k, output int ox, output int oy);
        ox = cx + DXT[k];
        oy = cy + DYT[k];
`ifdef ANT_SCAN_EDGE_WRAP_EN
        if (ox < 0) ox = XM - 1;
        if (ox >= XM) ox = 0;
        if (oy < 0) oy = YM - 1;
        if (oy >= YM) oy = 0;
        return 1'b1;
`else
        return !(ox < 0 || ox >= XM || oy < 0 || oy >= YM);
`endif
    endfunction

    task automatic expect_scan(input int cx, input int cy, input int cd);
        logic [7:0] m, r;
        int ox, oy;
        probe_t p;
        res_t rr;
        m = 8'd0;
        for (int k = 0; k < 8; k++) begin
            if (nb(cx, cy, k, ox, oy)) begin
                p.px = XB'(ox);
                p.py = YB'(oy);
                probe_q.push_back(p);
                m[k] = hit(mode, ox, oy);
            end
        end
        for (int i = 0; i < 8; i++) r[i] = m[(cd + i) % 8];
        rr.m = m;
        rr.r = r;
        rr.a = |m;
        res_q.push_back(rr);
    endtask

    // One clock: responder update and scoreboard checks at the falling edge.
    task automatic tick();
        probe_t p;
        res_t rr;
        @(posedge Clk);
        @(negedge Clk);
        sense     = resp_pend;
        resp_pend = viewValid && hit(mode, int'(viewLoc_x), int'(viewLoc_y));
        if (sb_en && viewValid) begin
            chk("probe_expected", (probe_q.size() > 0), 1);
            if (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                chk("probe_x", viewLoc_x, p.px);
                chk("probe_y", viewLoc_y, p.py);
            end
        end
        if (sb_en && done) begin
            chk("result_expected", (res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
                rr = res_q.pop_front();
                chk("mask", mask, rr.m);
                chk("rel_mask", rel_mask, rr.r);
                chk("any_hit", any_hit, rr.a);
            end
        end
    endtask

    // Cycles T1..T10 after an accepted start: done only in T10, busy until then.
    task automatic wait_scan(input string tag);
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("%s_done_c%0d", tag, c), done, (c == 10));
            chk($sformatf("%s_busy_c%0d", tag, c), busy, (c != 10));
        end
    endtask

    task automatic run_scan(input string tag, input int cx, input int cy, input int cd);
        start = 1'b1;
        x     = XB'(cx);
        y     = YB'(cy);
        dir   = 3'(cd);
        expect_scan(cx, cy, cd);
        tick();
        start = 1'b0;
        wait_scan(tag);
    endtask

    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        sense   = 1'b0;
        x       = 10'd0;
        y       = 9'd0;
        dir     = 3'd0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mask", mask, 0);
        chk("rst_valid", viewValid, 0);
        Reset_n = 1'b1;
        tick();

        // Reset in the middle of a scan; the in-flight sense must be discarded.
        sb_en = 1'b0;
        mode  = 1;
        start = 1'b1;
        x     = 10'd100;
        y     = 9'd100;
        dir   = 3'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_mask", mask, 0);
        chk("midrst_valid", viewValid, 0);
        chk("midrst_any", any_hit, 0);
        tick();
        Reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("midrst_no_done", done, 0);
            chk("midrst_mask_hold", mask, 0);
        end
        sb_en = 1'b1;

        // Interior scan and heading rotation.
        mode = 0;
        run_scan("interior", 100, 100, 0);
        chk("interior_mask_k", mask, 8'b0000_0010);
        chk("interior_rel_k", rel_mask, 8'b0000_0010);
        chk("interior_any_k", any_hit, 1);
        tick();
        chk("hold_mask", mask, 8'b0000_0010);
        run_scan("heading", 100, 100, 2);
        chk("heading_mask_k", mask, 8'b0000_0010);
        chk("heading_rel_k", rel_mask, 8'b1000_0000);

        // Grid corners.
        mode = 1;
        run_scan("corner00", 0, 0, 0);
`ifdef ANT_SCAN_EDGE_WRAP_EN
        chk("corner00_mask_k", mask, 8'hFF);
`else
        chk("corner00_mask_k", mask, 8'b0001_1100);
`endif
        run_scan("cornerMax", XM - 1, YM - 1, 3);

        // start held high: back-to-back scans, inputs changed mid-scan are ignored.
        mode  = 2;
        start = 1'b1;
        x     = 10'd200;
        y     = 9'd50;
        dir   = 3'd5;
        expect_scan(200, 50, 5);
        tick();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 3) begin
                x = 10'd300;
                y = 9'd60;
            end
            chk($sformatf("b2b_a_done_c%0d", c), done, (c == 10));
        end
        expect_scan(300, 60, 5);
        tick();
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("b2b_b_done_c%0d", c), done, (c == 10));
            chk($sformatf("b2b_b_busy_c%0d", c), busy, (c != 10));
        end
        start = 1'b0;
        tick();
        tick();

        chk("probe_q_empty", probe_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
